// File: rtl/spy_pkg.sv
// Shared definitions for the spy bus host port: address width, read-select
// and write-strobe bit indices, and the host port FSM state encodings.
package spy_pkg;

   localparam int unsigned SPY_ADDR_W = 5;
   localparam int unsigned SPY_DATA_W = 16;
   localparam int unsigned SPY_RSEL_W = 24;
   localparam int unsigned SPY_WSEL_W = 8;

   // Read-select bit positions (one-hot into the spy read mux)
   localparam int unsigned SPY_IRL     = 0;
   localparam int unsigned SPY_IRM     = 1;
   localparam int unsigned SPY_IRH     = 2;
   localparam int unsigned SPY_SCRATCH = 3;
   localparam int unsigned SPY_OPC     = 4;
   localparam int unsigned SPY_PC      = 5;
   localparam int unsigned SPY_OBL_N   = 6;
   localparam int unsigned SPY_OBH_N   = 7;
   localparam int unsigned SPY_OBL     = 8;
   localparam int unsigned SPY_OBH     = 9;
   localparam int unsigned SPY_FLAG1   = 10;
   localparam int unsigned SPY_FLAG2   = 11;
   localparam int unsigned SPY_ML      = 12;
   localparam int unsigned SPY_MH      = 13;
   localparam int unsigned SPY_AL      = 14;
   localparam int unsigned SPY_AH      = 15;
   localparam int unsigned SPY_STL     = 16;
   localparam int unsigned SPY_STH     = 17;
   localparam int unsigned SPY_MDL     = 18;
   localparam int unsigned SPY_MDH     = 19;
   localparam int unsigned SPY_VMAL    = 20;
   localparam int unsigned SPY_VMAH    = 21;
   localparam int unsigned SPY_BD      = 22;
   localparam int unsigned SPY_DISK    = 23;

   // Write-strobe bit positions (one-hot into the loadable registers)
   localparam int unsigned SPY_LDIRL    = 0;
   localparam int unsigned SPY_LDIRM    = 1;
   localparam int unsigned SPY_LDIRH    = 2;
   localparam int unsigned SPY_LDSCRATCH = 3;
   localparam int unsigned SPY_LDMODE   = 4;
   localparam int unsigned SPY_LDCLK    = 5;
   localparam int unsigned SPY_LDOPC    = 6;
   localparam int unsigned SPY_LDMD     = 7;

   // Address that returns the transaction counter when that option is built in
   localparam logic [SPY_ADDR_W-1:0] SPY_CNT_ADDR = 5'd31;

   // Host port FSM states
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEL  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_XFER = 3'd3;
   localparam logic [2:0] ST_ACK  = 3'd4;

endpackage

// File: rtl/spy_addr_decode.sv
// Combinational spy address decoder: {we, addr} -> one-hot read selects
// (reads) or one-hot write strobes (writes). Unmapped addresses decode to 0.
module spy_addr_decode
   import spy_pkg::*;
(
   input  logic                  we_i,
   input  logic [SPY_ADDR_W-1:0] addr_i,
   output logic [SPY_RSEL_W-1:0] rsel_o,
   output logic [SPY_WSEL_W-1:0] wsel_o
);

   // One-hot decode; only the vector matching the direction can be non-zero
   always_comb begin
      // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
      rsel_o = '0;
      wsel_o = '0;
      for (int i = 0; i < SPY_RSEL_W; i++) begin
         rsel_o[i] = !we_i && (addr_i == SPY_ADDR_W'(i));
      end
      for (int i = 0; i < SPY_WSEL_W; i++) begin
         wsel_o[i] = we_i && (addr_i == SPY_ADDR_W'(i));
      end
   end

endmodule

// File: rtl/spy_host_port.sv
// Host-side front end of the spy bus. Latches a single-word host request,
// drives registered read selects / dbread (reads) or write data plus a
// one-cycle write strobe (writes) after a programmable settle time, then
// returns a one-cycle ack (with captured read data for reads).
// Optional build macro SPY_XACT_CNT_EN: 16-bit transaction counter, readable
// at spy address 31.
module spy_host_port
   import spy_pkg::*;
#(
   parameter int unsigned SETTLE   = 2,
   parameter int unsigned SETTLE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [SPY_ADDR_W-1:0] host_addr,
   input  logic [SPY_DATA_W-1:0] host_wdata,
   output logic                  host_ack,
   output logic [SPY_DATA_W-1:0] host_rdata,
   input  logic [SPY_DATA_W-1:0] spy_in,
   output logic                  dbread,
   output logic [SPY_RSEL_W-1:0] spy_rsel,
   output logic [SPY_WSEL_W-1:0] spy_wsel,
   output logic [SPY_DATA_W-1:0] spy_wdata
);

   logic [2:0]            state_q, state_d;
   logic                  we_q, we_d;
   logic [SPY_ADDR_W-1:0] addr_q, addr_d;
   logic [SPY_DATA_W-1:0] wdata_q, wdata_d;
   logic [SETTLE_W-1:0]   cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic                  dbread_q, dbread_d;
   logic [SPY_RSEL_W-1:0] rsel_q, rsel_d;
   logic [SPY_WSEL_W-1:0] wsel_q, wsel_d;
   logic [SPY_DATA_W-1:0] rdata_q, rdata_d;
   logic [SPY_DATA_W-1:0] spy_wdata_q, spy_wdata_d;
   logic [SPY_RSEL_W-1:0] dec_rsel;
   logic [SPY_WSEL_W-1:0] dec_wsel;
   logic                  rd_enable;
   logic [SPY_DATA_W-1:0] rd_value;

   // Decode from the latched request so mid-transaction host changes are ignored
   spy_addr_decode u_decode (
      .we_i   (we_q),
      .addr_i (addr_q),
      .rsel_o (dec_rsel),
      .wsel_o (dec_wsel)
   );

`ifdef SPY_XACT_CNT_EN
   logic [SPY_DATA_W-1:0] xact_q, xact_d;

   // Count completed transactions; address 31 reads the count, not the mux
   always_comb begin
      xact_d    = (state_q == ST_ACK) ? xact_q + 16'd1 : xact_q;
      rd_enable = (addr_q != SPY_CNT_ADDR);
      rd_value  = rd_enable ? spy_in : xact_q;
   end

   // Transaction counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) xact_q <= '0;
      else       xact_q <= xact_d;
   end
`else
   // Without the counter every read goes through the spy mux
   always_comb begin
      rd_enable = 1'b1;
      rd_value  = spy_in;
   end
`endif

   // Next-state and next-output logic for the request sequencer
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      ack_d       = 1'b0;
      dbread_d    = dbread_q;
      rsel_d      = rsel_q;
      wsel_d      = wsel_q;
      rdata_d     = rdata_q;
      spy_wdata_d = spy_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (host_req) begin
               we_d    = host_we;
               addr_d  = host_addr;
               wdata_d = host_wdata;
               state_d = ST_SEL;
            end
         end
         ST_SEL: begin
            cnt_d = SETTLE_W'(SETTLE - 1);
            if (we_q) begin
               spy_wdata_d = wdata_q;
            end else begin
               rsel_d   = dec_rsel;
               dbread_d = rd_enable;
            end
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               // Write strobe covers exactly the XFER cycle
               wsel_d  = dec_wsel;
               state_d = ST_XFER;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_XFER: begin
            if (!we_q) rdata_d = rd_value;
            wsel_d   = '0;
            rsel_d   = '0;
            dbread_d = 1'b0;
            ack_d    = 1'b1;
            state_d  = ST_ACK;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transaction immediately
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         dbread_q    <= 1'b0;
         rsel_q      <= '0;
         wsel_q      <= '0;
         rdata_q     <= 16'hFFFF;
         spy_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         dbread_q    <= dbread_d;
         rsel_q      <= rsel_d;
         wsel_q      <= wsel_d;
         rdata_q     <= rdata_d;
         spy_wdata_q <= spy_wdata_d;
      end
   end

   assign host_ack   = ack_q;
   assign host_rdata = rdata_q;
   assign dbread     = dbread_q;
   assign spy_rsel   = rsel_q;
   assign spy_wsel   = wsel_q;
   assign spy_wdata  = spy_wdata_q;

endmodule

// File: tb/tb_spy_host_port.sv
// Directed self-checking bench for spy_host_port (SETTLE=2). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_spy_host_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_req;
   logic        host_we;
   logic [4:0]  host_addr;
   logic [15:0] host_wdata;
   logic        host_ack;
   logic [15:0] host_rdata;
   logic [15:0] spy_in;
   logic        dbread;
   logic [23:0] spy_rsel;
   logic [7:0]  spy_wsel;
   logic [15:0] spy_wdata;

   int n_checks = 0;
   int n_errors = 0;

   // Per-transaction observations
   int          ack_cyc;
   int          db_cnt;
   int          ws_cnt;
   logic [23:0] rsel_or;
   logic [7:0]  wsel_or;
   logic [15:0] wdata_ws;
   logic [15:0] rdata_ack;
   logic        overlap;
   logic        onehot_bad;
   logic        ack_next;
   int          extra_db;
   int          extra_ack;

   spy_host_port #(.SETTLE(2), .SETTLE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .spy_in     (spy_in),
      .dbread     (dbread),
      .spy_rsel   (spy_rsel),
      .spy_wsel   (spy_wsel),
      .spy_wdata  (spy_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request at a falling edge and watch it to completion (bounded).
   // drop: release host_req and scramble addr/wdata after the first cycle.
   // hold: keep host_req high through the ACK cycle.
   task automatic xact(input logic we, input logic [4:0] addr, input logic [15:0] wd,
                       input bit drop, input logic [4:0] late_addr, input bit hold);
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = addr;
      host_wdata = wd;
      ack_cyc = 0; db_cnt = 0; ws_cnt = 0; rsel_or = '0; wsel_or = '0;
      wdata_ws = '0; rdata_ack = '0; overlap = 1'b0; onehot_bad = 1'b0;
      for (int k = 1; k <= 20 && ack_cyc == 0; k++) begin
         @(negedge clk);
         if (drop) begin
            host_req   = 1'b0;
            host_addr  = late_addr;
            host_wdata = ~wd;
         end
         if (dbread) db_cnt++;
         if (spy_wsel != '0) begin
            ws_cnt++;
            wdata_ws = spy_wdata;
         end
         rsel_or |= spy_rsel;
         wsel_or |= spy_wsel;
         if (dbread && spy_wsel != '0) overlap = 1'b1;
         if ($countones(spy_rsel) > 1 || $countones(spy_wsel) > 1) onehot_bad = 1'b1;
         if (host_ack) begin
            ack_cyc   = k;
            rdata_ack = host_rdata;
         end
      end
      if (!hold) host_req = 1'b0;
      @(negedge clk);
      ack_next = host_ack;
      host_req = 1'b0;
   endtask

   // Idle for n cycles, counting any activity
   task automatic idle_watch(input int n);
      extra_db = 0; extra_ack = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (dbread) extra_db++;
         if (host_ack) extra_ack++;
      end
   endtask

   initial begin
      reset = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
      host_wdata = '0; spy_in = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ack",    32'(host_ack),   32'h0);
      check("rst_rdata",  32'(host_rdata), 32'hFFFF);
      check("rst_dbread", 32'(dbread),     32'h0);
      check("rst_rsel",   32'(spy_rsel),   32'h0);
      check("rst_wsel",   32'(spy_wsel),   32'h0);
      check("rst_wdata",  32'(spy_wdata),  32'h0);
      @(negedge clk);

      // Read addr 5 (pc)
      spy_in = 16'h1234;
      xact(1'b0, 5'd5, 16'h0000, 1'b0, 5'd0, 1'b0);
      check("rd5_ack_lat", 32'(ack_cyc),   32'd5);
      check("rd5_dbread",  32'(db_cnt),    32'd3);
      check("rd5_rsel",    32'(rsel_or),   32'h000020);
      check("rd5_nowsel",  32'(ws_cnt),    32'd0);
      check("rd5_rdata",   32'(rdata_ack), 32'h1234);
      check("rd5_ack1cyc", 32'(ack_next),  32'h0);
      check("rd5_rdhold",  32'(host_rdata), 32'h1234);

      // Write addr 3 (ldscratch)
      spy_in = 16'h5555;
      xact(1'b1, 5'd3, 16'hBEEF, 1'b0, 5'd0, 1'b0);
      check("wr3_wsel",    32'(wsel_or),   32'h08);
      check("wr3_wscnt",   32'(ws_cnt),    32'd1);
      check("wr3_wdata",   32'(wdata_ws),  32'hBEEF);
      check("wr3_nodb",    32'(db_cnt),    32'd0);
      check("wr3_norsel",  32'(rsel_or),   32'h0);
      check("wr3_overlap", 32'(overlap),   32'h0);
      check("wr3_ack_lat", 32'(ack_cyc),   32'd5);
      check("wr3_rdkeep",  32'(host_rdata), 32'h1234);

      // Write addr 7 (ldmd, highest strobe)
      xact(1'b1, 5'd7, 16'h0F0F, 1'b0, 5'd0, 1'b0);
      check("wr7_wsel",    32'(wsel_or),   32'h80);
      check("wr7_wdata",   32'(wdata_ws),  32'h0F0F);

      // Unmapped write addr 12
      xact(1'b1, 5'd12, 16'h1111, 1'b0, 5'd0, 1'b0);
      check("wr12_nostrb", 32'(wsel_or),   32'h0);
      check("wr12_ack",    32'(ack_cyc),   32'd5);

      // Read addr 23 (disk, highest select)
      spy_in = 16'h8001;
      xact(1'b0, 5'd23, 16'h0000, 1'b0, 5'd0, 1'b0);
      check("rd23_rsel",   32'(rsel_or),   32'h800000);
      check("rd23_rdata",  32'(rdata_ack), 32'h8001);

      // Unmapped read addr 26, mux default
      spy_in = 16'hFFFF;
      xact(1'b0, 5'd26, 16'h0000, 1'b0, 5'd0, 1'b0);
      check("rd26_rsel",   32'(rsel_or),   32'h0);
      check("rd26_dbread", 32'(db_cnt),    32'd3);
      check("rd26_rdata",  32'(rdata_ack), 32'hFFFF);
      check("rd26_ack",    32'(ack_cyc),   32'd5);

      // Read addr 2, request dropped and address changed to 9 mid-transaction
      spy_in = 16'hA5C3;
      xact(1'b0, 5'd2, 16'h0000, 1'b1, 5'd9, 1'b0);
      check("drop_rsel",   32'(rsel_or),   32'h000004);
      check("drop_ack",    32'(ack_cyc),   32'd5);
      check("drop_rdata",  32'(rdata_ack), 32'hA5C3);
      check("drop_onehot", 32'(onehot_bad), 32'h0);

      // host_req held through ACK must not start a new transaction
      spy_in = 16'h0042;
      xact(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1);
      check("hold_rsel",   32'(rsel_or),   32'h000001);
      check("hold_rdata",  32'(rdata_ack), 32'h0042);
      idle_watch(6);
      check("hold_nodb",   32'(extra_db),  32'd0);
      check("hold_noack",  32'(extra_ack), 32'd0);

      // Asynchronous reset in the middle of a read
      spy_in = 16'h7777;
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd4;
      repeat (2) @(negedge clk);
      host_req = 1'b0;
      check("abort_pre_db", 32'(dbread), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("abort_dbread", 32'(dbread),     32'h0);
      check("abort_rsel",   32'(spy_rsel),   32'h0);
      check("abort_rdata",  32'(host_rdata), 32'hFFFF);
      check("abort_ack",    32'(host_ack),   32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle_watch(8);
      check("abort_noack",  32'(extra_ack),  32'd0);
      check("abort_nodb",   32'(extra_db),   32'd0);

`ifdef SPY_XACT_CNT_EN
      // Three transactions after reset, then read the counter at address 31
      spy_in = 16'h2222;
      xact(1'b0, 5'd1, 16'h0000, 1'b0, 5'd0, 1'b0);
      xact(1'b1, 5'd4, 16'h3333, 1'b0, 5'd0, 1'b0);
      xact(1'b0, 5'd8, 16'h0000, 1'b0, 5'd0, 1'b0);
      xact(1'b0, 5'd31, 16'h0000, 1'b0, 5'd0, 1'b0);
      check("cnt_rdata",  32'(rdata_ack), 32'h0003);
      check("cnt_nodb",   32'(db_cnt),    32'd0);
      check("cnt_norsel", 32'(rsel_or),   32'h0);
`else
      // Address 31 is an ordinary unmapped read
      spy_in = 16'hFFFF;
      xact(1'b0, 5'd31, 16'h0000, 1'b0, 5'd0, 1'b0);
      check("rd31_rsel",   32'(rsel_or),   32'h0);
      check("rd31_dbread", 32'(db_cnt),    32'd3);
      check("rd31_rdata",  32'(rdata_ack), 32'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spy_host_port.md
Name: spy_host_port

Overview:
- Host-side front end of the spy bus.
- Accepts single-word read/write requests from the debug host (USB/serial bridge) and decodes the 5-bit spy address into one-hot read selects, dbread, and one-hot write strobes.
- On reads, waits a programmable settle time, captures the 16-bit spy read mux output, and returns it with an ack.
- Sits directly upstream of the spy read multiplexer and the spy-loadable registers (IR debug, scratch, mode, clock control).

Parameters:
- SETTLE, 2, cycles select/dbread are held before read capture or write strobe (1..15).
- SETTLE_W, 4, width of the settle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- host_req  in  1  request valid; held until host_ack
- host_we  in  1  1=write, 0=read; sampled with host_req in IDLE
- host_addr  in  5  spy register address
- host_wdata  in  16  write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  16  read data, valid while host_ack=1 and held until the next capture
- spy_in  in  16  spy mux output (already gated by dbread)
- dbread  out  1  read enable to the spy mux
- spy_rsel  out  24  one-hot read select: 0 irl, 1 irm, 2 irh, 3 scratch, 4 opc, 5 pc, 6 obl_, 7 obh_, 8 obl, 9 obh, 10 flag1, 11 flag2, 12 ml, 13 mh, 14 al, 15 ah, 16 stl, 17 sth, 18 mdl, 19 mdh, 20 vmal, 21 vmah, 22 bd, 23 disk
- spy_wsel  out  8  one-hot write strobe: 0 ldirl, 1 ldirm, 2 ldirh, 3 ldscratch, 4 ldmode, 5 ldclk, 6 ldopc, 7 ldmd
- spy_wdata  out  16  write data to loadable registers; valid while any spy_wsel bit is set

Behaviour:
- Reset (async, immediate): state=IDLE; dbread=0, spy_rsel=0, spy_wsel=0, host_ack=0, host_rdata=16'hFFFF, spy_wdata=0, counter=0.
- FSM states:
  - IDLE: on host_req, latch addr/we/wdata. Go to SEL.
  - SEL: drive the decoded select (read: spy_rsel bit + dbread=1; write: spy_wdata only, no strobe); load counter=SETTLE-1. Go to WAIT.
  - WAIT: hold selects; decrement the counter. When the counter reaches 0, go to XFER.
  - XFER:
    - Read: host_rdata<=spy_in.
    - Write: the spy_wsel bit is high for exactly this one cycle.
    - Go to ACK.
  - ACK: host_ack=1 for one cycle; all selects, dbread and spy_wsel low. Go to IDLE.
- Read latency from host_req sampled in IDLE to host_ack: SETTLE+3 cycles. Minimum request-to-request spacing is SETTLE+4 cycles.
- Selects are registered outputs; at most one spy_rsel bit and at most one spy_wsel bit is set in any cycle. dbread and spy_wsel are never set together.
- Unmapped read address (24..31): no spy_rsel bit set; dbread still asserted; host_rdata captures spy_in (the mux default is 16'hFFFF).
- Unmapped write address (8..31): no strobe; the transaction still completes with an ack.
- host_req deasserted mid-transaction: the transaction completes anyway. The host must not change addr/we/wdata until ack; they are latched in IDLE, so later changes are ignored.
- host_req still high in the ACK cycle: not a new request. A new request is sampled only in IDLE.
- Reset mid-transaction: selects and strobes drop asynchronously; no ack is produced for the aborted request.

Optional Feature:
- Macro SPY_XACT_CNT_EN.
- Defined:
  - 16-bit wrapping counter increments on every host_ack.
  - A read of address 31 returns the counter value instead of spy_in (no spy_rsel bit set, dbread=0).
  - Reset clears the counter.
- Undefined: no counter; address 31 behaves as any other unmapped read.

Decomposition:
- Shared package spy_pkg:
  - read index constants (SPY_IRL=0 ... SPY_DISK=23);
  - write index constants (SPY_LDIRL=0 ... SPY_LDMD=7);
  - the state enum (IDLE, SEL, WAIT, XFER, ACK);
  - the address width constant.
- One natural sub-module, spy_addr_decode: combinational decoder from {we, addr} to the rsel/wsel one-hot vectors. Outputs are registered in the parent.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs go to their reset values before the next clk edge; host_rdata=16'hFFFF.
- Read addr=5, spy_in=16'h1234, SETTLE=2 -> spy_rsel=24'h000020 with dbread=1 for 3 cycles; host_ack pulses 5 cycles after request; host_rdata=16'h1234.
- Write addr=3, wdata=16'hBEEF -> spy_wsel=8'h08 for exactly one cycle with spy_wdata=16'hBEEF; dbread=0 throughout; then host_ack.
- Read addr=26 -> spy_rsel=0, dbread=1, spy_in=16'hFFFF; host_rdata=16'hFFFF; ack still produced.
- host_req dropped after the first cycle, and addr changed from 2 to 9 mid-transaction -> spy_rsel stays bit 2; ack still produced.
- With SPY_XACT_CNT_EN: three transactions, then read addr 31 -> host_rdata=16'h0003 and dbread stays 0.
